digit_serial_add: RTL and testbench

- Multi-cycle, parametrised fixed-point adder/subtractor.
- Processes a W-bit digit per clock, LSB digit first, over D = N/W cycles, carrying between digits in a single carry register.
- Trades latency for area against the single-cycle full-width adders in the FixedPointArithmetic Add unit.
- Valid/ready handshakes on input and output, so it drops into streaming datapaths.

---
 rtl/digit_serial_add.sv | 186 ++++++++++++++++++
 tb/tb_digit_serial_add.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_add.sv
// -----------------------------------------------------------------------------
// digit_serial_add
//   Multi-cycle fixed-point adder/subtractor. Each RUN cycle processes one W-bit
//   digit, LSB digit first. A single carry register links the digits. A full
//   N-bit result takes D = N/W cycles from the accept edge.
//
//   Parameters:
//     N : operand/result width in bits
//     W : digit width in bits (N must be a multiple of W)
//
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   asynchronous active-high reset
//     in_valid  in   operands presented
//     in_ready  out  block idle and able to accept operands
//     a, b      in   N-bit operands
//     cx_in     in   carry in (add) / borrow in (sub)
//     sub       in   0: c = a + b + cx_in, 1: c = a - b - cx_in
//     out_valid out  result available
//     out_ready in   consumer accepts the result
//     c         out  N-bit result
//     co        out  carry out (for sub, 1 = no borrow)
//     ov        out  two's-complement signed overflow
//
//   Optional feature macro: DIGIT_SERIAL_ADD_SATURATE_EN
//     When defined and ov=1, c is replaced by the signed saturation value.
//     co and ov are reported unchanged, and latency does not change.
// -----------------------------------------------------------------------------
module digit_serial_add #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cx_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         co,
    output logic         ov
);

    localparam int D  = N / W;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    generate
        if ((N % W) != 0) begin : g_bad_digit_width
            $error("digit_serial_add: N must be a multiple of W");
        end
    endgenerate

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_c;
    logic            r_co;
    logic            r_ov;
    logic            r_carry;
    logic            r_a_msb;
    logic            r_b_msb;
    logic [CW-1:0]   r_k;

    logic [W:0]      w_sum;
    logic            w_ov;
    logic [N-1:0]    w_a_next;
    logic [N-1:0]    w_b_next;
    logic [N-1:0]    w_c_next;

`ifdef DIGIT_SERIAL_ADD_SATURATE_EN
    // Signed saturation value chosen by the sign of operand a
    function automatic logic [N-1:0] sat_value(input logic neg);
        logic [N-1:0] v;
        if (neg) begin
            v = {1'b1, {(N-1){1'b0}}};
        end else begin
            v = {1'b0, {(N-1){1'b1}}};
        end
        return v;
    endfunction
`endif

    // Digit adder: the low digit of each operand plus the running carry
    always_comb begin
        w_sum = {1'b0, r_a[W-1:0]} + {1'b0, r_b[W-1:0]} + {{W{1'b0}}, r_carry};
        // This is evaluated on the top digit, where w_sum[W-1] is the result sign
        w_ov  = (r_a_msb == r_b_msb) && (w_sum[W-1] != r_a_msb);
    end

    // Operand shift-down and result shift-in (LSB digit enters first, ends lowest)
    generate
        if (D == 1) begin : g_single_digit
            assign w_a_next = {N{1'b0}};
            assign w_b_next = {N{1'b0}};
            assign w_c_next = w_sum[W-1:0];
        end else begin : g_multi_digit
            assign w_a_next = {{W{1'b0}}, r_a[N-1:W]};
            assign w_b_next = {{W{1'b0}}, r_b[N-1:W]};
            assign w_c_next = {w_sum[W-1:0], r_c[N-1:W]};
        end
    endgenerate

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= {N{1'b0}};
            r_b         <= {N{1'b0}};
            r_c         <= {N{1'b0}};
            r_co        <= 1'b0;
            r_ov        <= 1'b0;
            r_carry     <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_k         <= {CW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + ~borrow
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_carry    <= sub ? ~cx_in : cx_in;
                        r_a_msb    <= a[N-1];
                        r_b_msb    <= sub ? ~b[N-1] : b[N-1];
                        r_k        <= {CW{1'b0}};
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    r_a     <= w_a_next;
                    r_b     <= w_b_next;
                    r_carry <= w_sum[W];
                    r_k     <= r_k + CW'(1);
                    r_c     <= w_c_next;
                    if (r_k == K_LAST) begin
                        r_co        <= w_sum[W];
                        r_ov        <= w_ov;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
`ifdef DIGIT_SERIAL_ADD_SATURATE_EN
                        if (w_ov) begin
                            r_c <= sat_value(r_a_msb);
                        end
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign co        = r_co;
    assign ov        = r_ov;

endmodule

// File: tb/tb_digit_serial_add.sv
module tb_digit_serial_add;

    typedef struct packed {
        logic [31:0] c;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        rst;
    // 32-bit, 8-bit digit instance
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cx_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        co;
    logic        ov;
    // 16-bit, single-digit instance
    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        out_valid16;
    logic [15:0] c16;
    logic        co16;
    logic        ov16;

    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t sb16[$];

    digit_serial_add #(.N(32), .W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cx_in(cx_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .co(co), .ov(ov)
    );

    digit_serial_add #(.N(16), .W(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cx_in(1'b0), .sub(1'b0),
        .out_valid(out_valid16), .out_ready(1'b1),
        .c(c16), .co(co16), .ov(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a result is handed over
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result32: got c=0x%08h with no pending op", c);
            end else begin
                e = sb.pop_front();
                chk("c32", c, e.c);
                chk("co32", {31'd0, co}, {31'd0, e.co});
                chk("ov32", {31'd0, ov}, {31'd0, e.ov});
            end
        end
        if (!rst && out_valid16) begin
            if (sb16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result16: got c=0x%04h with no pending op", c16);
            end else begin
                e = sb16.pop_front();
                chk("c16", {16'd0, c16}, e.c);
                chk("co16", {31'd0, co16}, {31'd0, e.co});
                chk("ov16", {31'd0, ov16}, {31'd0, e.ov});
            end
        end
    end

    // Present one operand set for exactly one accept edge and queue its expected result
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tcx,
                            input logic tsub, input logic [31:0] ec, input logic eco, input logic eov);
        exp_t e;
        e.c = ec; e.co = eco; e.ov = eov;
        sb.push_back(e);
        a = ta; b = tb; cx_in = tcx; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid, bounded
    task automatic wait_out(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n, exp_lat);
    endtask

    task automatic do_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tcx, input logic tsub,
                         input logic [31:0] ec, input logic eco, input logic eov);
        start_op(ta, tb, tcx, tsub, ec, eco, eov);
        wait_out(name, 4);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e16;
        int   n;
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; cx_in = 1'b0; sub = 1'b0;
        out_ready = 1'b1; in_valid16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
        #22;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_c", c, 32'd0);
        chk("rst_co_ov", {30'd0, co, ov}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("lat_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef DIGIT_SERIAL_ADD_SATURATE_EN
        do_op("lat_povf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
`else
        do_op("lat_povf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`endif
        do_op("lat_sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("lat_sub_pos", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
`ifdef DIGIT_SERIAL_ADD_SATURATE_EN
        do_op("lat_sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
        do_op("lat_sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

        // Backpressure: result must hold while new operands are offered and ignored
        out_ready = 1'b0;
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        wait_out("lat_bp", 4);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 32'hA5A5_0000 + i; b = 32'h0101_0101 * i; sub = i[1]; cx_in = i[2];
            @(posedge clk); #1;
            chk("bp_c_hold", c, 32'h2345_6789);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
`ifdef DIGIT_SERIAL_ADD_SATURATE_EN
        do_op("lat_novf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
`else
        do_op("lat_novf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
`endif

        // Reset two cycles after accept: the aborted op never produces a result
        a = 32'hDEAD_BEEF; b = 32'h0000_0101; cx_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_c", c, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("lat_after_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        // Single-digit instance: one RUN cycle
        e16.c = 32'd0;
`ifdef DIGIT_SERIAL_ADD_SATURATE_EN
        e16.c = 32'h0000_8000;
`endif
        e16.co = 1'b1; e16.ov = 1'b1;
        sb16.push_back(e16);
        a16 = 16'h8000; b16 = 16'h8000; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lat16", n, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("sb32_drained", sb.size(), 32'd0);
        chk("sb16_drained", sb16.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
